// File: rtl/udp_rx_parser.sv
// udp_rx_parser: strips Ethernet/IPv4/UDP headers from an Avalon-ST frame
// stream and forwards the UDP payload.
//   clk, reset_n           : rising-edge clock, async active-low reset
//   in_*  / in_ready       : Avalon-ST sink, first byte on data[31:24]
//   out_* / out_ready      : Avalon-ST payload source, one register stage
//   hdr_valid + header outs: one-cycle pulse when the header fields update
//   frames_ok/dropped/runt : 16-bit wrapping frame counters
module udp_rx_parser #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          ERROR_WIDTH     = 2,
    parameter logic [15:0] DST_PORT_FILTER = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [1:0]             in_empty,
    input  logic [ERROR_WIDTH-1:0] in_error,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [1:0]             out_empty,
    output logic [ERROR_WIDTH-1:0] out_error,
    input  logic                   out_ready,
    output logic                   hdr_valid,
    output logic [47:0]            src_mac,
    output logic [47:0]            dst_mac,
    output logic [31:0]            src_ip,
    output logic [31:0]            dst_ip,
    output logic [15:0]            src_port,
    output logic [15:0]            dst_port,
    output logic [15:0]            udp_length,
    output logic [15:0]            ip_total_len,
    output logic [7:0]             ttl,
    output logic [15:0]            frames_ok,
    output logic [15:0]            frames_dropped,
    output logic [15:0]            frames_runt
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [1:0]             empty;
        logic [ERROR_WIDTH-1:0] error;
    } beat_t;

    localparam logic [3:0] LAST_W = 4'd10;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    beat_t       ob;
    logic        first;
    logic        out_free, take, hdr_fail;
    logic        ev_w0, ev_runt, ev_drop, ev_hdr, ev_ok, ev_pay, ev_abort;
    logic [47:0] sh_dmac, sh_smac;
    logic [31:0] sh_sip, sh_dip;
    logic [15:0] sh_sport, sh_dport, sh_tlen;
    logic [7:0]  sh_ttl;

    assign out_free = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    // Field checks for the header word currently on the input.
    always_comb begin
        hdr_fail = (in_error != '0);
        case (cnt)
            4'd3: if (in_data[15:0] != 16'h0800) hdr_fail = 1'b1;
            4'd4: if (in_data[31:28] != 4'd4 || in_data[27:24] != 4'd5) hdr_fail = 1'b1;
            4'd6: if (in_data[23:16] != 8'h11) hdr_fail = 1'b1;
            4'd9: if (DST_PORT_FILTER != 16'h0 && in_data[15:0] != DST_PORT_FILTER) hdr_fail = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and event decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ev_w0 = 1'b0; ev_runt = 1'b0; ev_drop = 1'b0; ev_hdr = 1'b0;
        ev_ok = 1'b0; ev_pay  = 1'b0; ev_abort = 1'b0;
        case (state)
            IDLE: if (take && in_sop) ev_w0 = 1'b1;
            HDR: if (take) begin
                if (in_sop) begin
                    ev_w0   = 1'b1;
                    ev_runt = 1'b1;
                end else if (cnt != LAST_W && in_eop) begin
                    ev_runt = 1'b1; state_nxt = IDLE; cnt_nxt = 4'd0;
                end else if (hdr_fail) begin
                    ev_drop = 1'b1; state_nxt = in_eop ? IDLE : DROP; cnt_nxt = 4'd0;
                end else if (cnt == LAST_W) begin
                    ev_hdr  = 1'b1;
                    ev_ok   = in_eop;
                    state_nxt = in_eop ? IDLE : PAYLOAD;
                    cnt_nxt = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            PAYLOAD: begin
                // A new sop mid-payload is held off while the truncated
                // frame is closed with an error beat; IDLE then takes it.
                if (in_valid && in_sop) begin
                    if (out_free) begin
                        ev_abort = 1'b1; state_nxt = IDLE;
                    end
                end else if (take) begin
                    ev_pay = 1'b1;
                    if (in_eop) begin
                        ev_ok = 1'b1; state_nxt = IDLE;
                    end
                end
            end
            DROP: if (take) begin
                if (in_sop)      ev_w0 = 1'b1;
                else if (in_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (ev_w0) begin
            if (in_eop) begin
                ev_runt = 1'b1; state_nxt = IDLE; cnt_nxt = 4'd0;
            end else if (in_error != '0) begin
                ev_drop = 1'b1; state_nxt = DROP; cnt_nxt = 4'd0;
            end else begin
                state_nxt = HDR; cnt_nxt = 4'd1;
            end
        end
    end

    // Outputs: sink ready
    always_comb begin
        in_ready = out_free && !(state == PAYLOAD && in_valid && in_sop);
    end

    // Header shadow capture and publish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_dmac <= '0; sh_smac <= '0; sh_sip <= '0; sh_dip <= '0;
            sh_sport <= '0; sh_dport <= '0; sh_tlen <= '0; sh_ttl <= '0;
            hdr_valid <= 1'b0;
            src_mac <= '0; dst_mac <= '0; src_ip <= '0; dst_ip <= '0;
            src_port <= '0; dst_port <= '0; udp_length <= '0;
            ip_total_len <= '0; ttl <= '0;
        end else begin
            hdr_valid <= ev_hdr;
            if (ev_w0) sh_dmac[47:32] <= in_data[15:0];
            if (state == HDR && take && !in_sop) begin
                case (cnt)
                    4'd1: sh_dmac[31:0]  <= in_data;
                    4'd2: sh_smac[47:16] <= in_data;
                    4'd3: sh_smac[15:0]  <= in_data[31:16];
                    4'd4: sh_tlen        <= in_data[15:0];
                    4'd6: sh_ttl         <= in_data[31:24];
                    4'd7: sh_sip         <= in_data;
                    4'd8: sh_dip         <= in_data;
                    4'd9: begin
                        sh_sport <= in_data[31:16];
                        sh_dport <= in_data[15:0];
                    end
                    default: ;
                endcase
            end
            if (ev_hdr) begin
                dst_mac <= sh_dmac; src_mac <= sh_smac;
                src_ip <= sh_sip; dst_ip <= sh_dip;
                src_port <= sh_sport; dst_port <= sh_dport;
                ip_total_len <= sh_tlen; ttl <= sh_ttl;
                udp_length <= in_data[31:16];
            end
        end
    end

    // Payload output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ob        <= '0;
            out_valid <= 1'b0;
            first     <= 1'b0;
        end else begin
            if (ev_hdr) first <= 1'b1;
            if (ev_abort) begin
                ob        <= '{data: '0, sop: 1'b0, eop: 1'b1, empty: 2'd3,
                               error: ERROR_WIDTH'(2'b10)};
                out_valid <= 1'b1;
            end else if (ev_pay) begin
                ob        <= '{data: in_data, sop: first, eop: in_eop,
                               empty: in_empty, error: in_error};
                out_valid <= 1'b1;
                first     <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = ob.data;
    assign out_sop   = ob.sop;
    assign out_eop   = ob.eop;
    assign out_empty = ob.empty;
    assign out_error = ob.error;

    // Frame counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_ok <= '0; frames_dropped <= '0; frames_runt <= '0;
        end else begin
            if (ev_ok)   frames_ok      <= frames_ok + 16'd1;
            if (ev_drop) frames_dropped <= frames_dropped + 16'd1;
            if (ev_runt) frames_runt    <= frames_runt + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser: directed frames against udp_rx_parser with a payload
// monitor, header-pulse counter and stall-stability check.
module tb_udp_rx_parser;
    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
        logic [1:0]  err;
    } beat_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [1:0]  in_empty = '0, in_error = '0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_sop, out_eop;
    logic [1:0]  out_empty, out_error;
    logic        out_ready = 1'b1;
    logic        hdr_valid;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, udp_length, ip_total_len;
    logic [7:0]  ttl;
    logic [15:0] frames_ok, frames_dropped, frames_runt;

    udp_rx_parser #(.DATA_WIDTH(32), .ERROR_WIDTH(2), .DST_PORT_FILTER(16'h2382)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
        .hdr_valid(hdr_valid), .src_mac(src_mac), .dst_mac(dst_mac),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .udp_length(udp_length), .ip_total_len(ip_total_len), .ttl(ttl),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped), .frames_runt(frames_runt)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0, n_bad = 0;
    beat_t fq[$], eq[$], rq[$], eq_a[$];
    int    hcnt = 0;
    logic  tog = 1'b0;
    logic  held_v = 1'b0;
    beat_t held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // out_ready driver: steady 1, or alternating while tog is set
    initial forever begin
        @(negedge clk);
        out_ready = tog ? ~out_ready : 1'b1;
    end

    // Monitor: sampled mid-cycle, reflects the values seen at the next edge
    initial forever begin
        beat_t cur;
        @(negedge clk);
        #2;
        cur = '{d: out_data, sop: out_sop, eop: out_eop, emp: out_empty, err: out_error};
        if (reset_n) begin
            if (held_v) chk("stall_hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready) rq.push_back(cur);
            if (hdr_valid) hcnt++;
            held_v = out_valid && !out_ready;
            held   = cur;
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Header words for one frame plus payload; eq gets the expected output.
    task automatic build(input logic [7:0] proto, input logic [15:0] dport,
                         input int npay, input logic [1:0] lemp, input logic [31:0] pbase);
        logic [31:0] hw [11];
        fq.delete(); eq.delete();
        hw[0]  = 32'h0000_0011;
        hw[1]  = 32'h2233_4455;
        hw[2]  = 32'h6677_8899;
        hw[3]  = 32'hAABB_0800;
        hw[4]  = {16'h4500, 16'(28 + 4 * npay)};
        hw[5]  = 32'h1234_4000;
        hw[6]  = {8'h40, proto, 16'h0000};
        hw[7]  = 32'hC0A8_0001;
        hw[8]  = 32'hC0A8_0002;
        hw[9]  = {16'h1234, dport};
        hw[10] = {16'(8 + 4 * npay), 16'h0000};
        for (int i = 0; i < 11; i++)
            fq.push_back('{d: hw[i], sop: (i == 0), eop: (npay == 0 && i == 10), emp: 2'd0, err: 2'd0});
        for (int p = 0; p < npay; p++) begin
            beat_t b;
            b = '{d: pbase + 32'(p), sop: 1'b0, eop: (p == npay - 1),
                  emp: (p == npay - 1) ? lemp : 2'd0, err: 2'd0};
            fq.push_back(b);
            b.sop = (p == 0);
            eq.push_back(b);
        end
    endtask

    task automatic send_beat(input beat_t b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = b.d; in_sop = b.sop; in_eop = b.eop;
        in_empty = b.emp; in_error = b.err;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
    endtask

    task automatic send_fq();
        foreach (fq[i]) send_beat(fq[i]);
    endtask

    task automatic idle(input int cyc);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = '0;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic chk_rx(input string tag, input int exp_h);
        chk($sformatf("%s.nbeat", tag), 64'(rq.size()), 64'(eq.size()));
        for (int i = 0; i < eq.size() && i < rq.size(); i++)
            chk($sformatf("%s.beat%0d", tag, i), 64'(rq[i]), 64'(eq[i]));
        chk($sformatf("%s.hdr_pulses", tag), 64'(hcnt), 64'(exp_h));
        rq.delete();
        hcnt = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.dst_mac", 64'(dst_mac), 64'd0);
        chk("rst.counters", {16'h0, frames_ok, frames_dropped, frames_runt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // Valid frame, 3 payload words, empty=2 on last
        build(8'h11, 16'h2382, 3, 2'd2, 32'hA000_0000);
        send_fq(); idle(8);
        chk_rx("valid", 1);
        chk("valid.dst_port", 64'(dst_port), 64'h2382);
        chk("valid.src_port", 64'(src_port), 64'h1234);
        chk("valid.macs", {dst_mac[15:0], src_mac}, 64'h4455_6677_8899_AABB);
        chk("valid.ips", {src_ip, dst_ip}, 64'hC0A8_0001_C0A8_0002);
        chk("valid.lens", {24'h0, ttl, udp_length, ip_total_len}, {24'h0, 8'h40, 16'd20, 16'd40});
        chk("valid.ok", 64'(frames_ok), 64'd1);

        // TCP protocol -> dropped
        build(8'h06, 16'h2382, 3, 2'd2, 32'hB000_0000);
        eq.delete();
        send_fq(); idle(8);
        chk_rx("proto", 0);
        chk("proto.dropped", 64'(frames_dropped), 64'd1);

        // Runt: eop on w6, then a good frame
        build(8'h11, 16'h2382, 3, 2'd0, 32'hC000_0000);
        while (fq.size() > 7) void'(fq.pop_back());
        begin
            beat_t b;
            b = fq[6]; b.eop = 1'b1; fq[6] = b;
        end
        eq.delete();
        send_fq(); idle(4);
        chk_rx("runt", 0);
        chk("runt.count", 64'(frames_runt), 64'd1);
        build(8'h11, 16'h2382, 2, 2'd1, 32'hC100_0000);
        send_fq(); idle(8);
        chk_rx("after_runt", 1);
        chk("after_runt.ok", 64'(frames_ok), 64'd2);

        // Header-only frame
        build(8'h11, 16'h2382, 0, 2'd0, 32'h0);
        send_fq(); idle(8);
        chk_rx("hdr_only", 1);
        chk("hdr_only.udp_len", 64'(udp_length), 64'd8);
        chk("hdr_only.ok", 64'(frames_ok), 64'd3);

        // Destination port not matching the filter
        build(8'h11, 16'h1111, 2, 2'd0, 32'hD000_0000);
        eq.delete();
        send_fq(); idle(8);
        chk_rx("port_filter", 0);
        chk("port_filter.dropped", 64'(frames_dropped), 64'd2);

        // Error flag on a header beat (w2)
        build(8'h11, 16'h2382, 2, 2'd0, 32'hD100_0000);
        begin
            beat_t b;
            b = fq[2]; b.err = 2'b01; fq[2] = b;
        end
        eq.delete();
        send_fq(); idle(8);
        chk_rx("hdr_err", 0);
        chk("hdr_err.dropped", 64'(frames_dropped), 64'd3);

        // 20-word payload with out_ready toggling every cycle
        build(8'h11, 16'h2382, 20, 2'd0, 32'hE000_0000);
        tog = 1'b1;
        send_fq(); idle(10);
        tog = 1'b0;
        idle(4);
        chk_rx("toggle", 1);
        chk("toggle.ok", 64'(frames_ok), 64'd4);

        // sop during payload: truncated frame closed by an error beat
        build(8'h11, 16'h2382, 4, 2'd0, 32'hF000_0000);
        while (fq.size() > 13) void'(fq.pop_back());
        send_fq();
        eq_a = eq[0:1];
        eq_a.push_back('{d: 32'h0, sop: 1'b0, eop: 1'b1, emp: 2'd3, err: 2'b10});
        build(8'h11, 16'h2382, 2, 2'd3, 32'hF100_0000);
        eq = {eq_a, eq};
        send_fq(); idle(8);
        chk_rx("recover", 2);
        chk("recover.runt_drop", {frames_runt, frames_dropped}, {16'd1, 16'd3});

        // Reset pulsed during w5
        build(8'h11, 16'h2382, 2, 2'd0, 32'h1000_0000);
        for (int i = 0; i < 5; i++) send_beat(fq[i]);
        @(negedge clk);
        in_valid = 1'b1; in_data = fq[5].d; in_sop = 1'b0; in_eop = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("midrst.counters", {16'h0, frames_ok, frames_dropped, frames_runt}, 64'd0);
        chk("midrst.out", {out_valid, hdr_valid, out_data}, 64'd0);
        chk("midrst.hdr", {dst_port, src_ip}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rq.delete(); hcnt = 0;
        build(8'h11, 16'h2382, 2, 2'd1, 32'h2000_0000);
        send_fq(); idle(8);
        chk_rx("post_rst", 1);
        chk("post_rst.ok", 64'(frames_ok), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
